// File: rtl/grid_color_renderer.sv
// grid_color_renderer
// Double-buffered playfield renderer. Holds two COLS x ROWS banks of colour
// codes, maps each VGA pixel to a grid cell and drives registered 4-bit RGB
// through a programmable palette. Game logic writes the back bank and
// requests a commit; the front/back swap only happens on frame_start, so a
// displayed frame never mixes two buffer states.
//
// Ports
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank   current pixel and blanking flag from the VGA timer
//   frame_start           one-cycle strobe at the start of vertical blanking
//   wr_en/wr_col/wr_row/wr_code   back-bank cell write
//   commit                request a buffer swap at the next usable frame_start
//   clr                   clear the back bank to code 0
//   pal_we/pal_addr/pal_rgb       palette entry write
//   grid_lines, bg_rgb    gridline mode and colour outside the field
//   Red, Green, Blue      registered pixel colour (2-cycle latency)
//   commit_pending        commit latched but swap not yet performed
//   busy                  sweep engine running; cell writes are ignored
module grid_color_renderer #(
  parameter int          COLS        = 10,
  parameter int          ROWS        = 20,
  parameter int          CELL_W_LOG2 = 4,
  parameter int          CELL_H_LOG2 = 4,
  parameter int          X0          = 240,
  parameter int          Y0          = 80,
  parameter int          CODE_W      = 3,
  parameter logic [11:0] GRID_RGB    = 12'h444
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic                      frame_start,
  input  logic                      wr_en,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [CODE_W-1:0]         wr_code,
  input  logic                      commit,
  input  logic                      clr,
  input  logic                      pal_we,
  input  logic [CODE_W-1:0]         pal_addr,
  input  logic [11:0]               pal_rgb,
  input  logic                      grid_lines,
  input  logic [11:0]               bg_rgb,
  output logic [3:0]                Red,
  output logic [3:0]                Green,
  output logic [3:0]                Blue,
  output logic                      commit_pending,
  output logic                      busy
);

  localparam int NCELLS  = COLS * ROWS;
  localparam int IDX_W   = $clog2(NCELLS);
  localparam int NPAL    = 1 << CODE_W;
  localparam int FIELD_W = COLS << CELL_W_LOG2;
  localparam int FIELD_H = ROWS << CELL_H_LOG2;

  typedef enum logic [2:0] {
    ST_RST,
    ST_CLEAR_ALL,
    ST_IDLE,
    ST_CLEAR,
    ST_COPY
  } state_t;

  function automatic logic [11:0] palDefault(input int i);
    case (i)
      1:       return 12'hF00;
      2:       return 12'h0F0;
      3:       return 12'h00F;
      4:       return 12'hFF0;
      5:       return 12'hF0F;
      6:       return 12'hF70;
      7:       return 12'hF47;
      default: return 12'h000;
    endcase
  endfunction

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               front_q;
  logic               pending_q;
  logic [11:0]        pal_q [NPAL];
  logic [CODE_W-1:0]  bank0_q [NCELLS];
  logic [CODE_W-1:0]  bank1_q [NCELLS];

  logic               swapNow;
  logic               lastIdx;
  logic               wrInRange;
  logic [IDX_W-1:0]   wrAddr;
  logic               we0, we1;
  logic [IDX_W-1:0]   wAddr;
  logic [CODE_W-1:0]  wData;
  logic [CODE_W-1:0]  copyData;

  assign swapNow   = frame_start && pending_q && (state_q == ST_IDLE);
  assign lastIdx   = (idx_q == IDX_W'(NCELLS - 1));
  assign wrInRange = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
  assign wrAddr    = IDX_W'(IDX_W'(wr_row) * IDX_W'(COLS) + IDX_W'(wr_col));
  assign copyData  = front_q ? bank1_q[idx_q] : bank0_q[idx_q];

  assign busy           = (state_q == ST_CLEAR_ALL) || (state_q == ST_CLEAR) ||
                          (state_q == ST_COPY);
  assign commit_pending = pending_q;

  // Sweep FSM and buffer bookkeeping. ST_RST holds busy low during reset and
  // hands over to the full clear on the first clock after release. A swap
  // wins over clr when both arrive in the same idle cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RST;
      idx_q     <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      if (swapNow)
        pending_q <= 1'b0;
      else if (commit)
        pending_q <= 1'b1;

      case (state_q)
        ST_RST: begin
          state_q <= ST_CLEAR_ALL;
          idx_q   <= '0;
        end
        ST_IDLE: begin
          idx_q <= '0;
          if (swapNow) begin
            front_q <= ~front_q;
            state_q <= ST_COPY;
          end else if (clr) begin
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR_ALL, ST_CLEAR, ST_COPY: begin
          if (lastIdx) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_RST;
      endcase
    end
  end

  // Single write port per bank, shared by user writes (idle only) and the
  // sweep engine. The back bank is always the one not selected by front_q.
  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    wAddr = idx_q;
    wData = '0;
    case (state_q)
      ST_IDLE: begin
        if (wr_en && wrInRange) begin
          wAddr = wrAddr;
          wData = wr_code;
          we0   = front_q;
          we1   = ~front_q;
        end
      end
      ST_CLEAR_ALL: begin
        we0 = 1'b1;
        we1 = 1'b1;
      end
      ST_CLEAR: begin
        we0 = front_q;
        we1 = ~front_q;
      end
      ST_COPY: begin
        wData = copyData;
        we0   = front_q;
        we1   = ~front_q;
      end
      default: ;
    endcase
  end

  // Palette registers with their power-on colours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPAL; i++)
        pal_q[i] <= palDefault(i);
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_rgb;
    end
  end

  // Stage 1 combinational mapping. Offsets are 11 bits wide so pixels left
  // of or above the field fail the >= test instead of wrapping into range.
  logic [10:0]      xOff, yOff;
  logic [10:0]      colIdx, rowIdx;
  logic             inField;
  logic             gridHit;
  logic [IDX_W-1:0] pixAddr;

  assign xOff    = {1'b0, DrawX} - 11'(X0);
  assign yOff    = {1'b0, DrawY} - 11'(Y0);
  assign inField = ({1'b0, DrawX} >= 11'(X0)) && (xOff < 11'(FIELD_W)) &&
                   ({1'b0, DrawY} >= 11'(Y0)) && (yOff < 11'(FIELD_H));
  assign colIdx  = xOff >> CELL_W_LOG2;
  assign rowIdx  = yOff >> CELL_H_LOG2;
  assign gridHit = grid_lines && ((xOff[CELL_W_LOG2-1:0] == '0) ||
                                  (yOff[CELL_H_LOG2-1:0] == '0));
  assign pixAddr = inField ?
                   IDX_W'(IDX_W'(rowIdx) * IDX_W'(COLS) + IDX_W'(colIdx)) : '0;

  // Bank storage plus the dedicated synchronous read port for the pixel path.
  logic [CODE_W-1:0] code_q;

  always_ff @(posedge clk) begin
    if (we0) bank0_q[wAddr] <= wData;
    if (we1) bank1_q[wAddr] <= wData;
    code_q <= front_q ? bank1_q[pixAddr] : bank0_q[pixAddr];
  end

  // Stage 1 control flags travelling alongside the RAM read.
  logic inField_q, grid_q, blank_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inField_q <= 1'b0;
      grid_q    <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      inField_q <= inField;
      grid_q    <= gridHit;
      blank_q   <= blank;
    end
  end

  // Stage 2: palette lookup and output priority mux.
  logic [11:0] rgb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rgb_q <= 12'h000;
    else if (!blank_q)
      rgb_q <= 12'h000;
    else if (!inField_q)
      rgb_q <= bg_rgb;
    else if (grid_q)
      rgb_q <= GRID_RGB;
    else
      rgb_q <= pal_q[code_q];
  end

  assign Red   = rgb_q[11:8];
  assign Green = rgb_q[7:4];
  assign Blue  = rgb_q[3:0];

endmodule
